// File: rtl/posicion_actual.sv
// posicion_actual -- two-axis (theta, phi) stepper position keeper.
//
// Turns the four direction commands from the movement controller into
// rate-limited step/dir pulses. It integrates the issued steps into 16-bit
// actual-angle registers that feed back to the controller.
//
// A shared prescaler produces one step tick every PRESC clocks. Each axis
// runs its own IDLE/RUN_POS/RUN_NEG/DEAD machine, and that machine only
// advances on tick cycles.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   s_out_{theta,phi}_{pos,neg} direction commands
//   theta_actual, phi_actual   current positions (16-bit, saturating)
//   step_*, dir_*              one-cycle step pulse / direction (1 = positive)
//   lim_*                      position sits at MIN or MAX
//   conflict                   pos and neg both asserted on an axis (1-cycle latency)

module posicion_axis #(
    parameter int MIN        = 0,
    parameter int MAX        = 90,
    parameter int INIT       = 15,
    parameter int DEAD_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        cmd_pos,
    input  logic        cmd_neg,
    output logic [15:0] pos,
    output logic        step,
    output logic        dir,
    output logic        lim
);
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam logic [15:0] MIN_V  = 16'(MIN);
    localparam logic [15:0] MAX_V  = 16'(MAX);
    localparam logic [15:0] INIT_V = 16'(INIT);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TICKS - 1);

    typedef enum logic [1:0] {IDLE, RUN_POS, RUN_NEG, DEAD} state_t;

    state_t        state, state_n;
    logic [15:0]   pos_n;
    logic [DW-1:0] dead, dead_n;
    logic          step_n, dir_n;
    logic          up, dn;

    // pos & neg together counts as no command
    assign up = cmd_pos & ~cmd_neg;
    assign dn = cmd_neg & ~cmd_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= INIT_V;
            dead  <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            lim   <= (INIT_V == MIN_V) || (INIT_V == MAX_V);
        end else begin
            state <= state_n;
            pos   <= pos_n;
            dead  <= dead_n;
            step  <= step_n;
            dir   <= dir_n;
            // lim follows the position that lands on this edge, so it lines up with pos
            lim   <= (pos_n == MIN_V) || (pos_n == MAX_V);
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        dead_n  = dead;
        dir_n   = dir;
        step_n  = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (up && pos < MAX_V) begin
                        state_n = RUN_POS;
                        pos_n   = pos + 16'd1;
                        step_n  = 1'b1;
                        dir_n   = 1'b1;
                    end else if (dn && pos > MIN_V) begin
                        state_n = RUN_NEG;
                        pos_n   = pos - 16'd1;
                        step_n  = 1'b1;
                        dir_n   = 1'b0;
                    end
                end
                RUN_POS: begin
                    if (up && pos < MAX_V) begin
                        pos_n  = pos + 16'd1;
                        step_n = 1'b1;
                    end else if (dn) begin
                        // reversal: park the axis before dir may flip
                        state_n = DEAD;
                        dead_n  = DEAD_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
                RUN_NEG: begin
                    if (dn && pos > MIN_V) begin
                        pos_n  = pos - 16'd1;
                        step_n = 1'b1;
                    end else if (up) begin
                        state_n = DEAD;
                        dead_n  = DEAD_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    if (dead != '0) dead_n = dead - DW'(1);
                    else            state_n = IDLE;
                end
            endcase
        end
    end
endmodule

module posicion_actual #(
    parameter int PRESC      = 50000,
    parameter int DEAD_TICKS = 2,
    parameter int THETA_MIN  = 0,
    parameter int THETA_MAX  = 90,
    parameter int PHI_MIN    = 0,
    parameter int PHI_MAX    = 180,
    parameter int THETA_INIT = 15,
    parameter int PHI_INIT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_out_theta_pos,
    input  logic        s_out_theta_neg,
    input  logic        s_out_phi_pos,
    input  logic        s_out_phi_neg,
    output logic [15:0] theta_actual,
    output logic [15:0] phi_actual,
    output logic        step_theta,
    output logic        dir_theta,
    output logic        step_phi,
    output logic        dir_phi,
    output logic        lim_theta,
    output logic        lim_phi,
    output logic        conflict
);
    localparam int PW = (PRESC > 2) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            conflict <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            conflict <= (s_out_theta_pos & s_out_theta_neg) | (s_out_phi_pos & s_out_phi_neg);
        end
    end

    posicion_axis #(.MIN(THETA_MIN), .MAX(THETA_MAX), .INIT(THETA_INIT), .DEAD_TICKS(DEAD_TICKS)) u_theta (
        .clk(clk), .rst(rst), .tick(tick),
        .cmd_pos(s_out_theta_pos), .cmd_neg(s_out_theta_neg),
        .pos(theta_actual), .step(step_theta), .dir(dir_theta), .lim(lim_theta)
    );

    posicion_axis #(.MIN(PHI_MIN), .MAX(PHI_MAX), .INIT(PHI_INIT), .DEAD_TICKS(DEAD_TICKS)) u_phi (
        .clk(clk), .rst(rst), .tick(tick),
        .cmd_pos(s_out_phi_pos), .cmd_neg(s_out_phi_neg),
        .pos(phi_actual), .step(step_phi), .dir(dir_phi), .lim(lim_phi)
    );
endmodule

// File: tb/tb_posicion_actual.sv
// Randomized plus directed bench for posicion_actual (PRESC=4). Every cycle is
// compared against a tick-level behavioural model of the two axes.
module tb_posicion_actual;
    localparam int PRESC = 4;
    localparam int DEAD  = 2;
    localparam int MINV [2] = '{0, 0};
    localparam int MAXV [2] = '{90, 180};
    localparam int INITV[2] = '{15, 15};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tp = 1'b0, tn = 1'b0, pp = 1'b0, pn = 1'b0;
    logic [15:0] theta_actual, phi_actual;
    logic step_theta, dir_theta, step_phi, dir_phi, lim_theta, lim_phi, conflict;

    posicion_actual #(.PRESC(PRESC), .DEAD_TICKS(DEAD)) dut (
        .clk(clk), .rst(rst),
        .s_out_theta_pos(tp), .s_out_theta_neg(tn),
        .s_out_phi_pos(pp), .s_out_phi_neg(pn),
        .theta_actual(theta_actual), .phi_actual(phi_actual),
        .step_theta(step_theta), .dir_theta(dir_theta),
        .step_phi(step_phi), .dir_phi(dir_phi),
        .lim_theta(lim_theta), .lim_phi(lim_phi),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, cyc = 0;

    // model state: position, current motion (-1/0/+1), remaining quiet ticks
    int m_pos[2], m_mov[2], m_quiet[2];
    bit m_dir[2], m_step[2];
    bit m_conf;
    int m_phase;
    int n_step_phi;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            m_pos[a] = INITV[a]; m_mov[a] = 0; m_quiet[a] = 0;
            m_dir[a] = 1'b0; m_step[a] = 1'b0;
        end
        m_conf = 1'b0; m_phase = 0;
    endtask

    task automatic move(int a, int d);
        m_pos[a] += d; m_step[a] = 1'b1; m_dir[a] = (d > 0); m_mov[a] = d;
    endtask

    task automatic model_axis(int a, bit p, bit n);
        int want;
        m_step[a] = 1'b0;
        want = (p && !n) ? 1 : ((n && !p) ? -1 : 0);
        if (m_quiet[a] > 0) begin
            m_quiet[a]--;
        end else if (m_mov[a] == 0) begin
            if (want == 1 && m_pos[a] < MAXV[a])       move(a, 1);
            else if (want == -1 && m_pos[a] > MINV[a]) move(a, -1);
        end else if (want == m_mov[a] &&
                     (want == 1 ? m_pos[a] < MAXV[a] : m_pos[a] > MINV[a])) begin
            move(a, want);
        end else if (want == -m_mov[a]) begin
            m_quiet[a] = DEAD; m_mov[a] = 0;
        end else begin
            m_mov[a] = 0;
        end
    endtask

    // one clock: apply inputs, advance model, compare everything
    task automatic cycle(bit r, bit a_tp, bit a_tn, bit a_pp, bit a_pn);
        bit tick;
        rst = r; tp = a_tp; tn = a_tn; pp = a_pp; pn = a_pn;
        @(posedge clk);
        cyc++;
        if (r) begin
            model_reset();
        end else begin
            tick = (m_phase == PRESC - 1);
            m_phase = tick ? 0 : m_phase + 1;
            if (tick) begin
                model_axis(0, a_tp, a_tn);
                model_axis(1, a_pp, a_pn);
            end else begin
                m_step[0] = 1'b0; m_step[1] = 1'b0;
            end
            m_conf = (a_tp && a_tn) || (a_pp && a_pn);
        end
        #1;
        if (step_phi) n_step_phi++;
        chk("theta_actual", 32'(theta_actual), 32'(m_pos[0]));
        chk("phi_actual",   32'(phi_actual),   32'(m_pos[1]));
        chk("step_theta",   32'(step_theta),   32'(m_step[0]));
        chk("step_phi",     32'(step_phi),     32'(m_step[1]));
        chk("dir_theta",    32'(dir_theta),    32'(m_dir[0]));
        chk("dir_phi",      32'(dir_phi),      32'(m_dir[1]));
        chk("lim_theta",    32'(lim_theta),    32'(m_pos[0] == MINV[0] || m_pos[0] == MAXV[0]));
        chk("lim_phi",      32'(lim_phi),      32'(m_pos[1] == MINV[1] || m_pos[1] == MAXV[1]));
        chk("conflict",     32'(conflict),     32'(m_conf));
    endtask

    task automatic hold(int ncyc, bit a_tp, bit a_tn, bit a_pp, bit a_pn);
        for (int i = 0; i < ncyc; i++) cycle(1'b0, a_tp, a_tn, a_pp, a_pn);
    endtask

    initial begin
        model_reset();
        cycle(1'b1, 0, 0, 0, 0);
        cycle(1'b1, 0, 0, 0, 0);

        // theta up for 10 ticks: 15 -> 25
        hold(10 * PRESC, 1, 0, 0, 0);
        chk("theta_after_10", 32'(theta_actual), 32'd25);
        hold(2 * PRESC, 0, 0, 0, 0);

        // phi down 20 ticks: stops at 0 after exactly 15 pulses
        cycle(1'b1, 0, 0, 0, 0);
        n_step_phi = 0;
        hold(20 * PRESC, 0, 0, 0, 1);
        chk("phi_floor", 32'(phi_actual), 32'd0);
        chk("phi_pulses", 32'(n_step_phi), 32'd15);
        chk("lim_phi_floor", 32'(lim_phi), 32'd1);

        // reversal from 20: two dead ticks, then the next tick gives 19
        cycle(1'b1, 0, 0, 0, 0);
        hold(5 * PRESC, 1, 0, 0, 0);
        chk("theta_20", 32'(theta_actual), 32'd20);
        hold(4 * PRESC, 0, 1, 0, 0);
        chk("theta_19", 32'(theta_actual), 32'd19);

        // conflict on theta for 5 ticks
        hold(5 * PRESC, 1, 1, 0, 0);
        hold(2 * PRESC, 0, 0, 0, 0);

        // both up in lockstep, run theta to its upper limit, then reset mid-run
        hold(10 * PRESC, 1, 0, 1, 0);
        hold(80 * PRESC, 1, 0, 0, 0);
        chk("theta_ceiling", 32'(theta_actual), 32'd90);
        hold(3, 0, 1, 0, 0);
        cycle(1'b1, 0, 1, 0, 0);
        hold(2 * PRESC, 0, 1, 1, 0);

        // randomized command segments with occasional reset
        for (int s = 0; s < 150; s++) begin
            logic [3:0] c;
            int len;
            case ($urandom_range(0, 7))
                0: c = 4'b1000;
                1: c = 4'b0100;
                2: c = 4'b0010;
                3: c = 4'b0001;
                4: c = 4'b1010;
                5: c = 4'b1100;
                6: c = 4'b0000;
                default: c = 4'($urandom_range(0, 15));
            endcase
            len = $urandom_range(1, 30);
            if ($urandom_range(0, 19) == 0) cycle(1'b1, c[3], c[2], c[1], c[0]);
            hold(len, c[3], c[2], c[1], c[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/posicion_actual.md
Name: posicion_actual

Overview:
- Drives the two positioning axes (theta, phi) from the four direction commands that the movement controller produces (theta +/-, phi +/-).
- Generates rate-limited step/dir outputs for the stepper drivers.
- Integrates the issued steps into 16-bit actual-angle registers, which feed back to the controller as theta_actual / phi_actual.
- Enforces travel limits, a reversal dead-time, and conflicting-command rejection.

Parameters:
- PRESC, 50000: clock cycles per step tick (step rate = clk / PRESC); must be at least 2.
- DEAD_TICKS, 2: ticks the axis must stay stopped when a reversal is commanded.
- THETA_MIN, 0: lowest theta position (degrees).
- THETA_MAX, 90: highest theta position.
- PHI_MIN, 0: lowest phi position.
- PHI_MAX, 180: highest phi position.
- THETA_INIT, 15: theta position after reset.
- PHI_INIT, 15: phi position after reset.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset.
- s_out_theta_pos, in, 1: command theta up.
- s_out_theta_neg, in, 1: command theta down.
- s_out_phi_pos, in, 1: command phi up.
- s_out_phi_neg, in, 1: command phi down.
- theta_actual, out, 16: current theta position.
- phi_actual, out, 16: current phi position.
- step_theta, out, 1: one-cycle step pulse, theta.
- dir_theta, out, 1: theta direction, 1 = positive.
- step_phi, out, 1: one-cycle step pulse, phi.
- dir_phi, out, 1: phi direction, 1 = positive.
- lim_theta, out, 1: theta sits at THETA_MIN or THETA_MAX.
- lim_phi, out, 1: phi sits at PHI_MIN or PHI_MAX.
- conflict, out, 1: pos and neg are both asserted on either axis.

Interface: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
Reset:
- All registers are updated only on the rising edge of clk.
- While rst=1: prescaler=0, both FSMs=IDLE, theta_actual=THETA_INIT, phi_actual=PHI_INIT, step/dir=0, dead counters=0.
- lim_* and conflict are evaluated from the reset values.
- Reset mid-motion aborts immediately; no step pulse is issued in the reset cycle.

Prescaler:
- Shared counter running 0..PRESC-1.
- tick=1 for exactly one cycle when the count equals PRESC-1; the counter then wraps to 0.

Command decode (per axis, combinational from the inputs):
- up = pos & ~neg
- dn = neg & ~pos
- pos & neg is treated as no command.
- conflict = (theta_pos & theta_neg) | (phi_pos & phi_neg), registered with 1-cycle latency.

Per-axis FSM (states IDLE, RUN_POS, RUN_NEG, DEAD). Evaluated only on cycles where tick=1; otherwise state and position hold.
- IDLE:
  - up and pos<MAX: go to RUN_POS, pos+1, step pulse, dir=1.
  - dn and pos>MIN: go to RUN_NEG, pos-1, step pulse, dir=0.
  - Otherwise stay in IDLE.
- RUN_POS:
  - up and pos<MAX: pos+1, step pulse.
  - dn: go to DEAD, load dead counter with DEAD_TICKS-1, no step.
  - No command, or pos==MAX: go to IDLE, no step.
- RUN_NEG: mirror of RUN_POS (pos>MIN check, decrement; up leads to DEAD).
- DEAD:
  - Dead counter > 0: decrement, stay in DEAD.
  - Dead counter == 0: go to IDLE.
  - No steps are issued in DEAD regardless of commands.
  - Net effect: exactly DEAD_TICKS ticks without motion, then IDLE. The next tick may restart motion.

Step and direction outputs:
- A step pulse is high for exactly one clk cycle, the cycle after the tick edge. The position register updates on the same edge.
- dir changes only on a tick edge and never in the same cycle as a step of the opposite sense.
- dir holds its last value in IDLE/DEAD (initial value 0).

Arithmetic and limits:
- Positions are unsigned 16-bit and saturate at MIN/MAX; they never wrap.
- lim_* is registered and asserted whenever the position equals MIN or MAX.

Simultaneous events:
- The two axes are fully independent and may both step on the same tick.
- A command that changes between ticks is only sampled at tick.

Test Plan (PRESC=4, DEAD_TICKS=2, defaults otherwise):
1. Reset, then theta_pos=1 held for 10 ticks:
   - theta_actual increments 15→25, one step_theta pulse per tick, each 1 cycle wide, dir_theta=1.
   - phi_actual stays 15; conflict=0.
2. Reset, then phi_neg=1 held for 20 ticks:
   - phi_actual decrements to 0 after 15 steps, then stops; exactly 15 step_phi pulses; lim_phi=1.
   - FSM returns to IDLE and phi_actual never wraps to 65535.
3. Theta running positive (theta_actual=20), switch to theta_neg at the next tick:
   - No steps for 2 ticks (DEAD), then IDLE.
   - First negative step on the following tick gives 19; dir_theta goes 1→0 with no overlapping step.
4. theta_pos=theta_neg=1 for 5 ticks:
   - No steps, theta_actual unchanged, conflict=1 one cycle after assertion, 0 one cycle after release.
5. Both axes commanded up simultaneously:
   - step_theta and step_phi pulse in the same cycle every tick; positions advance in lockstep.
6. Assert rst for 1 cycle mid-run (theta_actual=40):
   - Next cycle theta_actual=15, phi_actual=15, step outputs 0, prescaler restarts so the first tick arrives after 4 cycles.
